// File: rtl/rf_clr_multi.sv
// rf_clr_multi: parametrised register file with two combinational read ports,
// one synchronous write port, per-entry valid bits and a sequenced bulk clear.
// Optional feature macro: RF_BYPASS_EN. When defined, an accepted write is
// forwarded to a read port whose address matches Rw in the same cycle.

// One storage entry: data word plus its valid bit.
module rf_clr_entry #(
   parameter int                DATA_W  = 16,
   parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
   input  logic              gclk,
   input  logic              grst_n,
   input  logic              we_i,
   input  logic              clr_i,
   input  logic [DATA_W-1:0] wdat_i,
   output logic [DATA_W-1:0] dat_o,
   output logic              vld_o
);

   logic [DATA_W-1:0] dat_q;
   logic              vld_q;

   // Clear and write are never both asserted: writes are refused while clearing.
   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         dat_q <= CLR_VAL;
         vld_q <= 1'b0;
      end else if (clr_i) begin
         dat_q <= CLR_VAL;
         vld_q <= 1'b0;
      end else if (we_i) begin
         dat_q <= wdat_i;
         vld_q <= 1'b1;
      end
   end

   assign dat_o = dat_q;
   assign vld_o = vld_q;

endmodule

module rf_clr_multi #(
   parameter int                DATA_W  = 16,
   parameter int                ADDR_W  = 4,
   parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
   input  logic              gclk,
   input  logic              grst_n,
   input  logic [ADDR_W-1:0] Ra_i,
   input  logic [ADDR_W-1:0] Rb_i,
   input  logic [ADDR_W-1:0] Rw_i,
   input  logic              WrEn_i,
   input  logic [DATA_W-1:0] Wdat_i,
   input  logic              ClrReq_i,
   output logic [DATA_W-1:0] Adat_o,
   output logic [DATA_W-1:0] Bdat_o,
   output logic              Avld_o,
   output logic              Bvld_o,
   output logic              Busy_o,
   output logic              WrDrop_o
);

   localparam int                DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = '1;

   typedef enum logic {IDLE, CLEAR} state_e;

   state_e                        state_q, state_d;
   logic [ADDR_W-1:0]             cnt_q, cnt_d;
   logic                          wrdrop_q, wrdrop_d;
   logic                          busy;
   logic                          wr_acc;
   logic [DEPTH-1:0][DATA_W-1:0]  mem;
   logic [DEPTH-1:0]              vld;

   assign busy   = (state_q == CLEAR);
   assign wr_acc = WrEn_i && !busy;

   // Storage: one entry per address, write and clear strobes decoded here.
   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      rf_clr_entry #(
         .DATA_W  (DATA_W),
         .CLR_VAL (CLR_VAL)
      ) u_entry (
         .gclk   (gclk),
         .grst_n (grst_n),
         .we_i   (wr_acc && (Rw_i == ADDR_W'(g))),
         .clr_i  (busy && (cnt_q == ADDR_W'(g))),
         .wdat_i (Wdat_i),
         .dat_o  (mem[g]),
         .vld_o  (vld[g])
      );
   end

   // Clear sequencer state, sweep counter and refused-write flag.
   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         wrdrop_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wrdrop_q <= wrdrop_d;
      end
   end

   // Next state: ClrReq only matters in IDLE; the sweep ends after the last entry
   // and the counter wraps back to zero on its own.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wrdrop_d = WrEn_i && busy;
      case (state_q)
         IDLE: begin
            if (ClrReq_i) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Combinational read ports, with optional same-cycle write forwarding.
   always_comb begin
      Adat_o = mem[Ra_i];
      Avld_o = vld[Ra_i];
      Bdat_o = mem[Rb_i];
      Bvld_o = vld[Rb_i];
`ifdef RF_BYPASS_EN
      if (wr_acc && (Rw_i == Ra_i)) begin
         Adat_o = Wdat_i;
         Avld_o = 1'b1;
      end
      if (wr_acc && (Rw_i == Rb_i)) begin
         Bdat_o = Wdat_i;
         Bvld_o = 1'b1;
      end
`else
`endif
   end

   assign Busy_o   = busy;
   assign WrDrop_o = wrdrop_q;

endmodule
